// File: rtl/aln_collector_if.sv
// Stream bundle between the traceback stage, the alignment collector and its consumer.
// The collector uses the slave modport; the traceback side and the consumer use master.
interface aln_collector_if #(
  parameter int L = 8
);
  localparam int CW = $clog2(2*L+1);

  // Handshake: a pair moves on every rising clk edge where out_valid && out_ready.
  // Once out_valid is high, it and out_r/out_q/out_last stay unchanged until that transfer.
  logic          start_traceback;
  logic [2:0]    in_r;
  logic [2:0]    in_q;
  logic          in_finish;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_r;
  logic [2:0]    out_q;
  logic          out_last;
  logic [CW-1:0] aln_len;
  logic [CW-1:0] n_match;
  logic [CW-1:0] n_mismatch;
  logic [CW-1:0] n_gap;
  logic          done;
  logic          overflow;
  logic [1:0]    state;

  modport master (
    output start_traceback, in_r, in_q, in_finish, out_ready,
    input  out_valid, out_r, out_q, out_last, aln_len, n_match, n_mismatch, n_gap,
           done, overflow, state
  );

  modport slave (
    input  start_traceback, in_r, in_q, in_finish, out_ready,
    output out_valid, out_r, out_q, out_last, aln_len, n_match, n_mismatch, n_gap,
           done, overflow, state
  );
endinterface

// File: rtl/aln_collector.sv
// Collects traceback pairs (arriving end-to-start) into a LIFO, replays them start-to-end
// over a valid/ready stream and keeps alignment length and match/mismatch/gap counts.
module aln_collector #(
  parameter int L = 8
) (
  input  logic           clk,
  input  logic           rst,
  aln_collector_if.slave bus
);
  localparam int DEPTH = 2*L;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t        state, state_next;
  logic [5:0]    mem [DEPTH];
  logic [CW-1:0] aln_len, rd_ptr, n_match, n_mismatch, n_gap, len_after;
  logic          overflow, out_valid, out_last;
  logic [2:0]    out_r, out_q;
  logic          pair_valid, is_gap, full, push, xfer;

  assign pair_valid = (bus.in_r != 3'b111) && (bus.in_q != 3'b111);
  assign is_gap     = (bus.in_r == 3'b100) || (bus.in_q == 3'b100);
  assign full       = (aln_len == CW'(DEPTH));
  assign push       = (state == CAPTURE) && bus.start_traceback && pair_valid && !full;
  assign len_after  = aln_len + {{(CW-1){1'b0}}, push};
  assign xfer       = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_traceback) state_next = CAPTURE;
      CAPTURE: begin
        if (!bus.start_traceback) state_next = IDLE;
        else if (bus.in_finish)   state_next = (len_after != '0) ? DRAIN : DONE;
      end
      DRAIN:   if (xfer && out_last) state_next = DONE;
      DONE:    if (!bus.start_traceback) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // LIFO storage; aln_len doubles as the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem[AW'(aln_len)] <= {bus.in_r, bus.in_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aln_len    <= '0;
      rd_ptr     <= '0;
      n_match    <= '0;
      n_mismatch <= '0;
      n_gap      <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_r      <= 3'b111;
      out_q      <= 3'b111;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_traceback) begin
            aln_len    <= '0;
            rd_ptr     <= '0;
            n_match    <= '0;
            n_mismatch <= '0;
            n_gap      <= '0;
            overflow   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!bus.start_traceback) begin
            aln_len    <= '0;
            rd_ptr     <= '0;
            n_match    <= '0;
            n_mismatch <= '0;
            n_gap      <= '0;
          end else begin
            if (pair_valid && full) overflow <= 1'b1;
            if (push) begin
              aln_len <= aln_len + CW'(1);
              if (is_gap)                 n_gap      <= n_gap + CW'(1);
              else if (bus.in_r == bus.in_q) n_match <= n_match + CW'(1);
              else                        n_mismatch <= n_mismatch + CW'(1);
            end
            if (bus.in_finish) rd_ptr <= len_after;
          end
        end
        DRAIN: begin
          // Reload the output register whenever it is empty or its pair is leaving.
          if (xfer && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_r     <= 3'b111;
            out_q     <= 3'b111;
          end else if ((!out_valid || bus.out_ready) && (rd_ptr != '0)) begin
            out_valid <= 1'b1;
            out_last  <= (rd_ptr == CW'(1));
            {out_r, out_q} <= mem[AW'(rd_ptr - CW'(1))];
            rd_ptr    <= rd_ptr - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_last   = out_last;
  assign bus.out_r      = out_r;
  assign bus.out_q      = out_q;
  assign bus.aln_len    = aln_len;
  assign bus.n_match    = n_match;
  assign bus.n_mismatch = n_mismatch;
  assign bus.n_gap      = n_gap;
  assign bus.overflow   = overflow;
  assign bus.done       = (state == DONE);
  assign bus.state      = state;
endmodule
